ap_ctrl_driver: RTL
===================

Name: ap_ctrl_driver

Overview:
- Initiator side of the ap_ctrl_chain block-level handshake (ap_start/ap_ready/ap_done/ap_continue) used by our HLS kernels.
- Issues a programmed number of kernel transactions to a DUT top or sub-function and acknowledges completions.
- Measures per-transaction start-to-done latency and asserts finish when the run drains.
- Sits in the simulation testbench beside the dataflow monitors and drives the kernel they observe.

Parameters:
- CNT_W, 16, width of transaction counters and cfg_num_trans.
- LAT_W, 32, width of cycle timestamp and latency outputs.
- MAX_OUTSTANDING, 4, maximum accepted-but-not-done transactions (power of 2, ≥1); timestamp FIFO depth.
- CONT_DELAY, 0, cycles between ap_done first seen and ap_continue assertion; 0 = ap_continue held high while busy.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cfg_start  in  1  one-cycle pulse, begins a run; honoured only in IDLE or DONE.
- cfg_num_trans  in  CNT_W  transactions per run; sampled on cfg_start.
- ap_start  out  1  to DUT.
- ap_ready  in  1  from DUT.
- ap_done  in  1  from DUT.
- ap_continue  out  1  to DUT.
- busy  out  1  high in RUN or DRAIN.
- finish  out  1  level, high in DONE.
- starts_issued  out  CNT_W  accepted starts this run.
- dones_seen  out  CNT_W  consumed dones this run.
- lat_valid  out  1  one-cycle pulse per consumed done.
- last_latency  out  LAT_W  latency of most recent done.
- max_latency  out  LAT_W  maximum latency this run.
- error  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, cycle counter 0. Reset mid-run aborts immediately; outputs read 0 on the cycle after reset is sampled.
- Cycle counter cyc: free-running LAT_W, cleared to 0 on cfg_start, wraps modulo 2^LAT_W.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE on cfg_start: latch cfg_num_trans, clear both counters, max_latency, last_latency and error. Go to DONE if num==0, else RUN.
- RUN: ap_start=1 while starts_issued<num and outstanding<MAX_OUTSTANDING.
  - Accept = ap_start&&ap_ready in the same cycle. On accept: starts_issued+1, push cyc into FIFO.
  - ap_start stays high until ap_ready; it is never withdrawn before acceptance. Back-to-back accepts are allowed.
  - When starts_issued reaches num (counting an accept in the current cycle), ap_start drops the next cycle and state goes to DRAIN.
- DRAIN: ap_start=0. When dones_seen reaches num, go to DONE.
- DONE: finish=1, busy=0, ap_continue=0. Counters and latencies hold.
- ap_continue:
  - CONT_DELAY=0: ap_continue=busy.
  - Otherwise a delay counter starts on the first cycle ap_done=1 while busy, and ap_continue pulses high for one cycle after CONT_DELAY cycles. The DUT holds ap_done until ap_continue.
- Consume = ap_done&&ap_continue. On consume:
  - pop FIFO, latency = cyc - timestamp (modular);
  - dones_seen+1, lat_valid=1 next cycle;
  - last_latency=latency; max_latency=max(max_latency, latency).
- Simultaneous accept and consume in one cycle: push and pop both occur; outstanding unchanged.
- Consume with empty FIFO and an accept in the same cycle: latency 0, no push/pop.
- error is set sticky by:
  - consume with empty FIFO and no accept in that cycle (counter unchanged);
  - ap_ready=1 while ap_start=0 in RUN;
  - ap_done=1 in IDLE or DONE.
- cfg_start in RUN/DRAIN is ignored.

Test Plan:
- num=4; ap_ready tied high; DUT raises ap_done 5 cycles after each accept; CONT_DELAY=0 -> 4 accepts, 4 lat_valid pulses, last_latency=5, max_latency=5, finish=1, starts_issued=dones_seen=4.
- num=1; ap_ready asserted 3 cycles after ap_start rises -> ap_start high exactly 4 cycles, starts_issued=1, single FIFO push.
- MAX_OUTSTANDING=2, num=5; DUT withholds ap_done -> exactly 2 accepts, ap_start low; releasing one done -> ap_start high next cycle, third accept.
- CONT_DELAY=2; DUT holds ap_done -> ap_continue high only on 3rd cycle of ap_done; dones_seen increments once; no error.
- cfg_start with num=0 -> finish=1 next cycle, ap_start never asserted, busy stays 0.
- ap_done pulse in IDLE -> error=1 and stays 1. Reset asserted mid-RUN with 2 outstanding -> all outputs 0 next cycle; a new cfg_start runs cleanly with error=0.

Source files
------------

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: initiator side of the ap_ctrl_chain block-level handshake.
//
// Issues cfg_num_trans kernel transactions (ap_start/ap_ready), acknowledges
// completions (ap_done/ap_continue), timestamps every accepted start in a small
// FIFO and reports start-to-done latency for every consumed done.
//
// Parameters:
//   CNT_W           width of transaction counters and cfg_num_trans
//   LAT_W           width of the cycle counter and latency outputs
//   MAX_OUTSTANDING accepted-but-not-done limit, also timestamp FIFO depth
//   CONT_DELAY      cycles from first ap_done to the ap_continue pulse;
//                   0 holds ap_continue high while busy
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cfg_start, cfg_num_trans  run request and transaction count (IDLE/DONE only)
//   ap_start, ap_ready        start handshake to/from the kernel
//   ap_done, ap_continue      completion handshake from/to the kernel
//   busy, finish              run in progress / run drained
//   starts_issued, dones_seen per-run transaction counters
//   lat_valid, last_latency   pulse + latency for each consumed done
//   max_latency               largest latency seen this run
//   error                     sticky protocol violation flag
module ap_ctrl_driver #(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned LAT_W           = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CONT_DELAY      = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_trans,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] starts_issued,
    output logic [CNT_W-1:0] dones_seen,
    output logic             lat_valid,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DLY_W = $clog2(CONT_DELAY + 2);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((CONT_DELAY > 0) ? CONT_DELAY - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] starts_q, starts_d;
    logic [CNT_W-1:0] dones_q, dones_d;
    logic [LAT_W-1:0] cyc_q;
    logic [LAT_W-1:0] last_q, last_d;
    logic [LAT_W-1:0] max_q, max_d;
    logic [LAT_W-1:0] latency;
    logic [LAT_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             cont_q, cont_d;
    logic             lat_valid_q;
    logic             error_q, error_d;

    logic idle_like, cfg_go, accept, consume, fifo_empty, push, pop, done_ok, proto_err;

    always_comb begin
        idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        finish     = (state_q == ST_DONE);
        cfg_go     = cfg_start && idle_like;
        ap_start   = (state_q == ST_RUN) && (starts_q < num_q) && (occ_q < OCC_FULL);

        accept     = ap_start && ap_ready;
        consume    = ap_done && ap_continue;
        fifo_empty = (occ_q == '0);
        // An accept and a consume meeting an empty FIFO cancel out: the
        // transaction completes in its own start cycle with zero latency.
        pop        = consume && !fifo_empty;
        push       = accept && !(consume && fifo_empty);
        done_ok    = consume && (!fifo_empty || accept);
        latency    = fifo_empty ? '0 : (cyc_q - fifo_mem[rd_ptr_q]);

        proto_err  = (consume && fifo_empty && !accept)
                   || ((state_q == ST_RUN) && ap_ready && !ap_start)
                   || (ap_done && idle_like);

        starts_d   = starts_q + CNT_W'(accept);
        dones_d    = dones_q + CNT_W'(done_ok);
        last_d     = done_ok ? latency : last_q;
        max_d      = (done_ok && (latency > max_q)) ? latency : max_q;
        error_d    = error_q || proto_err;

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_go) begin
                    state_d = (cfg_num_trans == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (starts_d == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dones_d == num_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delayed-continue: count cycles of a held ap_done, then pulse ap_continue
    // once; the count restarts for the next done.
    always_comb begin
        dly_d  = '0;
        cont_d = 1'b0;
        if ((CONT_DELAY != 0) && busy && ap_done && !cont_q) begin
            if (dly_q == DLY_LAST) begin
                cont_d = 1'b1;
            end else begin
                dly_d = dly_q + DLY_W'(1);
            end
        end
        ap_continue = (CONT_DELAY == 0) ? busy : cont_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            starts_q    <= '0;
            dones_q     <= '0;
            cyc_q       <= '0;
            last_q      <= '0;
            max_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            dly_q       <= '0;
            cont_q      <= 1'b0;
            lat_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else if (cfg_go) begin
            state_q     <= state_d;
            num_q       <= cfg_num_trans;
            starts_q    <= '0;
            dones_q     <= '0;
            cyc_q       <= '0;
            last_q      <= '0;
            max_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            dly_q       <= '0;
            cont_q      <= 1'b0;
            lat_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starts_q    <= starts_d;
            dones_q     <= dones_d;
            cyc_q       <= cyc_q + LAT_W'(1);
            last_q      <= last_d;
            max_q       <= max_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            dly_q       <= dly_d;
            cont_q      <= cont_d;
            lat_valid_q <= done_ok;
            error_q     <= error_d;
        end
    end

    // Timestamp storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cyc_q;
        end
    end

    assign starts_issued = starts_q;
    assign dones_seen    = dones_q;
    assign lat_valid     = lat_valid_q;
    assign last_latency  = last_q;
    assign max_latency   = max_q;
    assign error         = error_q;

endmodule
